// File: rtl/dp_ram_pipe.sv
// Simple dual-port RAM with byte enables, a fully pipelined read path of RD_LAT stages,
// selectable read-during-write behaviour and a registered out-of-range flag.
module dp_ram_pipe #(
    parameter int AW        = 16,
    parameter int DW        = 32,
    parameter int DATA_SIZE = 1024,
    parameter int RD_LAT    = 2,
    parameter int RDW_MODE  = 0
) (
    input  logic            clock,
    input  logic            rst_n,
    input  logic [DW-1:0]   data,
    input  logic [AW-1:0]   wraddress,
    input  logic            wren,
    input  logic [DW/8-1:0] byteena,
    input  logic            rden,
    input  logic [AW-1:0]   rdaddress,
    output logic [DW-1:0]   q,
    output logic            q_valid,
    output logic            addr_err
);

    localparam int NB = DW / 8;
    localparam int IW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [AW:0] DEPTH = (AW + 1)'(DATA_SIZE);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $fatal(1, "dp_ram_pipe: RD_LAT=%0d outside 1..4", RD_LAT);
    end
    if (DW % 8 != 0 || DW < 8) begin : g_bad_dw
        $fatal(1, "dp_ram_pipe: DW=%0d is not a multiple of 8", DW);
    end

    logic [DW-1:0] mem [0:DATA_SIZE-1];

    logic          rd_ok;
    logic          wr_ok;
    logic          fwd;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;
    logic [DW-1:0] rd_word;

    logic [DW-1:0] stage_q [1:RD_LAT];
    logic [RD_LAT:1] stage_v;

    // Comparison is done one bit wider so DATA_SIZE == 2^AW never wraps to zero.
    assign rd_ok  = ({1'b0, rdaddress} < DEPTH);
    assign wr_ok  = ({1'b0, wraddress} < DEPTH);
    assign rd_idx = rdaddress[IW-1:0];
    assign wr_idx = wraddress[IW-1:0];
    assign fwd    = (RDW_MODE == 1) && wren && wr_ok && (wraddress == rdaddress);

    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            rd_word = mem[rd_idx];
            if (fwd) begin
                for (int b = 0; b < NB; b++) begin
                    if (byteena[b]) rd_word[8*b +: 8] = data[8*b +: 8];
                end
            end
        end
    end

    // Memory has no reset; writes are suppressed while rst_n is low.
    always_ff @(posedge clock) begin
        if (rst_n && wren && wr_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (byteena[b]) mem[wr_idx][8*b +: 8] <= data[8*b +: 8];
            end
        end
    end

    // Data stages only load behind a valid so the last stage holds q between results.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= RD_LAT; k++) stage_q[k] <= '0;
            stage_v  <= '0;
            addr_err <= 1'b0;
        end else begin
            if (rden) stage_q[1] <= rd_word;
            stage_v[1] <= rden;
            for (int k = 2; k <= RD_LAT; k++) begin
                if (stage_v[k-1]) stage_q[k] <= stage_q[k-1];
                stage_v[k] <= stage_v[k-1];
            end
            addr_err <= (rden && !rd_ok) || (wren && !wr_ok);
        end
    end

    assign q       = stage_q[RD_LAT];
    assign q_valid = stage_v[RD_LAT];

endmodule
